ps2_host_ctrl: RTL

//  Host-side controller for the bidirectional PS/2 bus (open-drain ps2_clk/ps2_dat).

---
 rtl/ps2_host_ctrl.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/ps2_host_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ps2_host_ctrl
// Purpose  : Host-side PS/2 bus controller. Receives device frames with
//            start/parity/stop checking, transmits host commands (inhibit,
//            request-to-send, bit shift, ACK) and arbitrates the shared
//            open-drain clock/data lines between the two directions.
// Revision : 1.0  initial release
// ============================================================================
module ps2_host_ctrl #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic       CLOCK_50,
   input  logic       Resetn,
   inout  wire        ps2_clk,
   inout  wire        ps2_dat,
   input  logic [7:0] cmd_data,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_err,
   output logic       tx_done,
   output logic       tx_err,
   output logic       busy
);

   localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RX       = 3'd1,
      TX_INH   = 3'd2,
      TX_RTS   = 3'd3,
      TX_SHIFT = 3'd4,
      TX_ACK   = 3'd5
   } state_t;

   state_t           state, state_n;
   logic             clk_s1, clk_s2, clk_prev, dat_s1, dat_s2;
   logic             fall, timeout;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [3:0]       bitcnt, bitcnt_n;
   logic [8:0]       rx_sr, rx_sr_n;      // received d0..d7, parity (LSB-first)
   logic [9:0]       rx_frame;            // {stop, parity, d7..d0} once the 11th bit arrives
   logic [10:0]      tx_sr, tx_sr_n;      // bit 0 is the bit currently presented on ps2_dat
   logic [7:0]       rx_data_n;
   logic             rx_valid_n, rx_err_n, tx_done_n, tx_err_n;
   logic             clk_low, dat_low;

   // Two-flop synchronisers on both bus lines plus a delayed clock copy for edge detection
   always_ff @(posedge CLOCK_50) begin
      if (!Resetn) begin
         clk_s1   <= 1'b1;
         clk_s2   <= 1'b1;
         clk_prev <= 1'b1;
         dat_s1   <= 1'b1;
         dat_s2   <= 1'b1;
      end else begin
         clk_s1   <= ps2_clk;
         clk_s2   <= clk_s1;
         clk_prev <= clk_s2;
         dat_s1   <= ps2_dat;
         dat_s2   <= dat_s1;
      end
   end

   assign fall = clk_prev & ~clk_s2;

   // Next-state, datapath updates and pulse generation for the bus sequencer
   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      bitcnt_n   = bitcnt;
      rx_sr_n    = rx_sr;
      tx_sr_n    = tx_sr;
      rx_data_n  = rx_data;
      rx_valid_n = 1'b0;
      rx_err_n   = 1'b0;
      tx_done_n  = 1'b0;
      tx_err_n   = 1'b0;
      cmd_ready  = 1'b0;
      rx_frame   = {dat_s2, rx_sr};
      timeout    = (cnt == TO_LAST) && !fall;
      case (state)
         IDLE: begin
            cnt_n     = '0;
            cmd_ready = Resetn & ~fall;
            // A device start bit has priority; a pending command simply waits
            if (fall && !dat_s2) begin
               state_n  = RX;
               bitcnt_n = 4'd1;
            end else if (cmd_valid && !fall) begin
               tx_sr_n = {1'b1, ~^cmd_data, cmd_data, 1'b0};
               state_n = TX_INH;
            end
         end
         RX: begin
            if (fall) begin
               cnt_n    = '0;
               rx_sr_n  = rx_frame[9:1];
               bitcnt_n = bitcnt + 4'd1;
               if (bitcnt == 4'd10) begin
                  state_n  = IDLE;
                  bitcnt_n = '0;
                  if ((^rx_frame[8:0]) && rx_frame[9]) begin
                     rx_data_n  = rx_frame[7:0];
                     rx_valid_n = 1'b1;
                  end else begin
                     rx_err_n = 1'b1;
                  end
               end
            end else if (timeout) begin
               state_n  = IDLE;
               bitcnt_n = '0;
               rx_err_n = 1'b1;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         TX_INH: begin
            if (cnt == INH_LAST) begin
               state_n = TX_RTS;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         TX_RTS: begin
            bitcnt_n = '0;
            if (timeout) begin
               state_n  = IDLE;
               tx_err_n = 1'b1;
            end else begin
               state_n = TX_SHIFT;
               cnt_n   = '0;
            end
         end
         TX_SHIFT: begin
            if (fall) begin
               cnt_n    = '0;
               tx_sr_n  = {1'b1, tx_sr[10:1]};
               bitcnt_n = bitcnt + 4'd1;
               // Tenth fall puts the stop bit on the line
               if (bitcnt == 4'd9) begin
                  state_n = TX_ACK;
               end
            end else if (timeout) begin
               state_n  = IDLE;
               tx_err_n = 1'b1;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         TX_ACK: begin
            if (fall) begin
               state_n = IDLE;
               if (!dat_s2) begin
                  tx_done_n = 1'b1;
               end else begin
                  tx_err_n = 1'b1;
               end
            end else if (timeout) begin
               state_n  = IDLE;
               tx_err_n = 1'b1;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // State, datapath and registered status pulses
   always_ff @(posedge CLOCK_50) begin
      if (!Resetn) begin
         state    <= IDLE;
         cnt      <= '0;
         bitcnt   <= '0;
         rx_sr    <= '0;
         tx_sr    <= '1;
         rx_data  <= 8'h00;
         rx_valid <= 1'b0;
         rx_err   <= 1'b0;
         tx_done  <= 1'b0;
         tx_err   <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         bitcnt   <= bitcnt_n;
         rx_sr    <= rx_sr_n;
         tx_sr    <= tx_sr_n;
         rx_data  <= rx_data_n;
         rx_valid <= rx_valid_n;
         rx_err   <= rx_err_n;
         tx_done  <= tx_done_n;
         tx_err   <= tx_err_n;
      end
   end

   // Open-drain drivers: lines are only ever pulled low or released
   assign clk_low = (state == TX_INH);
   assign dat_low = ((state == TX_RTS) || (state == TX_SHIFT) || (state == TX_ACK)) && !tx_sr[0];
   assign ps2_clk = clk_low ? 1'b0 : 1'bz;
   assign ps2_dat = dat_low ? 1'b0 : 1'bz;
   assign busy    = (state != IDLE);

endmodule
`default_nettype wire
